// File: rtl/iter_divider.sv
// iter_divider
//   Multicycle integer divide/remainder unit covering DIV/DIVU/REM/REMU and
//   their word (W) forms. Raw register operands go in; sign correction,
//   divide-by-zero and signed overflow are resolved internally.
//   Normal ops run a restoring radix-2 loop: one quotient bit per cycle,
//   N = XLEN (or XLEN/2 in word mode) iterations.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high
//   in_valid   request present           in_ready   1 iff IDLE
//   op         00 DIV 01 DIVU 10 REM 11 REMU
//   word       W-form: low-half operands, sign-extended result
//   a, b       dividend, divisor
//   flush      drop any in-flight or pending operation
//   out_valid  result present (high only in DONE)
//   out_ready  consumer takes result
//   result     quotient or remainder, registered
//   busy       state != IDLE
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | iterating, one quotient bit per cycle
// DONE  | result held until out_ready
module iter_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int H  = XLEN / 2;
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] ONE = XLEN'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  // Latched operation context
  logic [XLEN-1:0] quo_r;   // dividend shifts out of the top, quotient in at the bottom
  logic [XLEN-1:0] dvsr_r;
  logic [XLEN-1:0] rem_r;
  logic [CW-1:0]   cnt_r;
  logic            is_rem_r;
  logic            word_r;
  logic            neg_q_r;
  logic            neg_r_r;

  // Acceptance-time decode
  logic            accept;
  logic            is_signed;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] min_neg;
  logic [XLEN-1:0] a_n;
  logic [XLEN-1:0] b_n;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            b_zero;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] spec_res;

  // Iteration datapath
  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [CW-1:0]   cnt_nx;
  logic            calc_end;
  logic [XLEN-1:0] calc_res;

  // Optional negate, then sign-extend from bit H-1 in word mode. Negating
  // the full width and keeping the low half is the same as negating mod 2^H.
  function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] v,
                                          input logic            neg,
                                          input logic            w);
    logic [XLEN-1:0] t;
    t = neg ? (~v + ONE) : v;
    return w ? {{H{t[H-1]}}, t[H-1:0]} : t;
  endfunction

  always_comb begin
    accept    = in_valid && in_ready && !flush;
    is_signed = ~op[0];
    mask      = word ? {{H{1'b0}}, {H{1'b1}}} : {XLEN{1'b1}};
    min_neg   = word ? {{H{1'b0}}, 1'b1, {(H-1){1'b0}}}
                     : {1'b1, {(XLEN-1){1'b0}}};
    a_n       = a & mask;
    b_n       = b & mask;
    sign_a    = is_signed & (word ? a[H-1] : a[XLEN-1]);
    sign_b    = is_signed & (word ? b[H-1] : b[XLEN-1]);
    // Most-negative value maps to 2^(N-1), which still fits as unsigned N bits
    mag_a     = sign_a ? ((~a_n + ONE) & mask) : a_n;
    mag_b     = sign_b ? ((~b_n + ONE) & mask) : b_n;
    b_zero    = (b_n == '0);
    ovf       = is_signed && (a_n == min_neg) && (b_n == mask);
    special   = b_zero || ovf;
    // b == 0: q = all ones, r = a.  Overflow: q = a, r = 0.
    if (op[1])
      spec_res = fin(b_zero ? a_n : '0, 1'b0, word);
    else
      spec_res = fin(b_zero ? mask : a_n, 1'b0, word);
  end

  always_comb begin
    rem_sh   = {rem_r, quo_r[XLEN-1]};
    ge       = (rem_sh >= {1'b0, dvsr_r});
    // True difference is below the divisor, so the low XLEN bits are exact
    rem_nx   = ge ? (rem_sh[XLEN-1:0] - dvsr_r) : rem_sh[XLEN-1:0];
    quo_nx   = {quo_r[XLEN-2:0], ge};
    cnt_nx   = cnt_r - CW'(1);
    calc_end = (cnt_nx == '0);
    if (is_rem_r)
      calc_res = fin(rem_nx, neg_r_r && (rem_nx != '0), word_r);
    else
      calc_res = fin(quo_nx, neg_q_r, word_r);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (accept)    state_nx = special ? DONE : CALC;
        CALC: if (calc_end)  state_nx = DONE;
        DONE: if (out_ready) state_nx = IDLE;
        default:             state_nx = IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_r    <= '0;
      dvsr_r   <= '0;
      rem_r    <= '0;
      cnt_r    <= '0;
      is_rem_r <= 1'b0;
      word_r   <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      result   <= '0;
    end else if (flush) begin
      cnt_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Word operands are left-aligned so the MSB shift is width-agnostic
            quo_r    <= word ? {mag_a[H-1:0], {H{1'b0}}} : mag_a;
            dvsr_r   <= mag_b;
            rem_r    <= '0;
            cnt_r    <= special ? '0 : (word ? CW'(H) : CW'(XLEN));
            is_rem_r <= op[1];
            word_r   <= word;
            neg_q_r  <= sign_a ^ sign_b;
            neg_r_r  <= sign_a;
            if (special) result <= spec_res;
          end
        end
        CALC: begin
          quo_r <= quo_nx;
          rem_r <= rem_nx;
          cnt_r <= cnt_nx;
          if (calc_end) result <= calc_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
module tb_iter_divider;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic            word;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  int          lat_q[$];

  iter_divider #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .a(a), .b(b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model built on the language's own division operators
  function automatic logic [63:0] ext(input logic [63:0] x, input logic w, input logic s);
    if (!w)     return x;
    else if (s) return {{32{x[31]}}, x[31:0]};
    else        return {32'd0, x[31:0]};
  endfunction

  function automatic logic is_special(input logic [1:0] o, input logic w,
                                      input logic [63:0] x, input logic [63:0] y);
    logic [63:0] xe, ye, mn;
    xe = ext(x, w, ~o[0]);
    ye = ext(y, w, ~o[0]);
    mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    return (ye == 64'd0) || (!o[0] && xe == mn && ye == '1);
  endfunction

  function automatic logic [63:0] model(input logic [1:0] o, input logic w,
                                        input logic [63:0] x, input logic [63:0] y);
    logic [63:0] xe, ye, q, r, v, mn;
    logic signed [63:0] sx, sy;
    xe = ext(x, w, ~o[0]);
    ye = ext(y, w, ~o[0]);
    mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    if (ye == 64'd0) begin
      q = '1; r = xe;
    end else if (!o[0] && xe == mn && ye == '1) begin
      q = xe; r = 64'd0;
    end else if (!o[0]) begin
      sx = xe; sy = ye;
      q = sx / sy; r = sx % sy;
    end else begin
      q = xe / ye; r = xe % ye;
    end
    v = o[1] ? r : q;
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic w,
                                   input logic [63:0] x, input logic [63:0] y);
    if (is_special(o, w, x, y)) return 1;
    return w ? 33 : 65;
  endfunction

  // Issue one op, then pop its expected result when out_valid rises.
  // Latency counts the accept edge as edge 1.
  task automatic run_op(input logic [1:0] o, input logic w, input logic [63:0] x,
                        input logic [63:0] y, input logic [63:0] e, input int el,
                        input int hold, input string name);
    int lat, waitc;
    logic [63:0] exp_v;
    int exp_l;
    exp_q.push_back(e);
    lat_q.push_back(el);
    @(negedge clk);
    op = o; word = w; a = x; b = y; in_valid = 1'b1;
    out_ready = (hold == 0);
    waitc = 0;
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_issue: in_ready=%b required 1", name, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    op = 2'($urandom_range(0, 3));
    word = 1'($urandom_range(0, 1));
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    exp_v = exp_q.pop_front();
    exp_l = lat_q.pop_front();
    n_checks++;
    if (lat !== exp_l || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d edges (out_valid=%b) required %0d", name, lat, out_valid, exp_l);
    end
    n_checks++;
    if (result !== exp_v) begin
      n_fail++;
      $display("FAIL %s_result: got %h required %h", name, result, exp_v);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp_v) begin
        n_fail++;
        $display("FAIL %s_hold%0d: out_valid=%b in_ready=%b result=%h required 1 0 %h",
                 name, i, out_valid, in_ready, result, exp_v);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_handoff: in_ready=%b out_valid=%b required 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; op = 2'd0; word = 1'b0;
    a = '0; b = '0; flush = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b result=%h required 1 0 0 0",
               in_ready, out_valid, busy, result);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    run_op(2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 65, 0, "divu_100_7");
    run_op(2'b11, 1'b0, 64'd100, 64'd7, 64'd2,  65, 0, "remu_100_7");
  endtask

  task automatic test_signed();
    run_op(2'b00, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0, "div_m7_2");
    run_op(2'b10, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0, "rem_m7_2");
    run_op(2'b10, 1'b0, 64'd7, -64'sd2, 64'd1, 65, 0, "rem_7_m2");
  endtask

  task automatic test_div_zero();
    run_op(2'b00, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, "div_by_zero");
    run_op(2'b10, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0, "rem_by_zero");
    run_op(2'b01, 1'b1, 64'h1234_5678_8000_0001, 64'hFFFF_FFFF_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 1, 0, "divuw_by_zero");
  endtask

  task automatic test_overflow();
    run_op(2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0, "div_ovf");
    run_op(2'b10, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0, "rem_ovf");
    run_op(2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1, 0, "divw_ovf");
  endtask

  task automatic test_word();
    run_op(2'b01, 1'b1, 64'hDEAD_BEEF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0, "divuw_b1");
    run_op(2'b10, 1'b1, -64'sd9, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0, "remw_m9_4");
  endtask

  task automatic test_hold();
    run_op(2'b01, 1'b0, 64'd1000, 64'd10, 64'd100, 65, 10, "hold_done");
  endtask

  task automatic test_flush();
    logic seen;
    @(negedge clk);
    op = 2'b01; word = 1'b0; a = 64'd100; b = 64'd7; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: busy=%b in_ready=%b out_valid=%b required 0 1 0", busy, in_ready, out_valid);
    end
    @(negedge clk);
    flush = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_result: out_valid rose=%b required 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    op = 2'b01; word = 1'b0; a = 64'd100; b = 64'd7; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid_calc: in_ready=%b out_valid=%b busy=%b result=%h required 1 0 0 0",
               in_ready, out_valid, busy, result);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 65, 0, "divu_after_reset");
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic        w;
    logic [63:0] x, y;
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      x = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) y = {$urandom, $urandom};
      else                           y = 64'($urandom_range(0, 20));
      if ($urandom_range(0, 1) == 1) y = -y;
      run_op(o, w, x, y, model(o, w, x, y), model_lat(o, w, x, y), 0, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_word();
    test_hold();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
# iter_divider

Parametrised multicycle integer divide/remainder unit for the execute stage. It covers all eight RV64M divide ops (DIV/DIVU/REM/REMU and the W forms). It handles sign correction, divide-by-zero and signed overflow internally, so execute passes raw register operands instead of pre-negating them. Issue and result use valid/ready handshakes, with flush support for pipeline redirects. Word-mode ops take XLEN/2 iterations instead of XLEN.

## Interface
- XLEN, 64, datapath width; even, ≥ 8
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- in_valid  in  1  request present
- in_ready  out  1  block can accept; 1 iff state == IDLE
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- word  in  1  1 = W-form: use a[XLEN/2-1:0], b[XLEN/2-1:0], sign-extend result
- a  in  XLEN  dividend
- b  in  XLEN  divisor
- flush  in  1  discard any in-flight or pending operation
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- result  out  XLEN  quotient or remainder per op
- busy  out  1  state != IDLE

## Operation
- Accept: edge where in_valid && in_ready && !flush. op, word, a and b are latched; inputs may change afterwards.
- Effective width: N = word ? XLEN/2 : XLEN. Operands are truncated to N bits; upper bits are ignored.
- Signed ops (DIV, REM): latch |a| and |b| as N-bit magnitudes. Record neg_q = sign(a) ^ sign(b) and neg_r = sign(a).
- Special cases resolve at acceptance, with no iteration:
  - b == 0: quotient = all ones (N bits), remainder = a (N bits).
  - Signed and a == most-negative N-bit value and b == -1: quotient = a, remainder = 0.
- Normal case: restoring radix-2 division, one quotient bit per CALC cycle, N cycles. Each cycle: rem = {rem, dividend MSB}; if rem ≥ divisor, subtract and set the quotient bit to 1. The internal remainder is N+1 bits wide.
- Finalise on entry to DONE:
  - Negate the quotient if neg_q.
  - Negate the remainder if neg_r and the remainder is nonzero.
  - Select the quotient or remainder per op.
- Word mode: result = sign-extension of bit XLEN/2-1 of the N-bit value. This applies to DIVUW/REMUW too, per RV64.
- FSM:
  - IDLE → CALC on normal accept.
  - IDLE → DONE on special-case accept.
  - CALC → DONE when the iteration counter reaches 0.
  - DONE → IDLE on out_valid && out_ready.
  - Any state → IDLE on flush.
- There is no acceptance in DONE. The next request waits until the cycle after handoff.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, busy 0, in_ready 1, counter 0, internal registers 0. Reset acts immediately (async) and overrides flush and in_valid.
- Latency, counted from the accept edge to the edge where out_valid rises:
  - normal: N+1 edges (65 for XLEN = 64, 33 in word mode)
  - special case: 1 edge
- out_valid is registered; it is high only in DONE.
- result is registered and stable for the whole time out_valid is high, regardless of out_ready or input changes.
- flush:
  - Takes priority over accept and over the DONE handoff.
  - The next state is IDLE; out_valid is 0 on the next edge and the result is discarded.
  - flush while in IDLE is a no-op.
- Handoff: with out_ready held at 1, DONE lasts exactly one cycle. in_ready rises the cycle after handoff.
- Reset or flush mid-CALC: the iteration counter is cleared. A later request starts clean and gets its full latency.

## Test plan
- DIVU a=100, b=7 → result 14, out_valid exactly 65 edges after accept. REMU with the same operands → 2.
- DIV a=-7, b=2 → 0xFFFF_FFFF_FFFF_FFFD (-3). REM → 0xFFFF_FFFF_FFFF_FFFF (-1). REM a=7, b=-2 → 1.
- Divide by zero:
  - DIV a=5, b=0 → 0xFFFF_FFFF_FFFF_FFFF after 1 edge; REM → 5.
  - DIVUW a=0x1234_5678_8000_0001, b=0xFFFF_FFFF_0000_0000 → 0xFFFF_FFFF_FFFF_FFFF.
- Overflow:
  - DIV a=0x8000_0000_0000_0000, b=-1 → 0x8000_0000_0000_0000; REM → 0.
  - DIVW a=0x8000_0000, b=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000. Each after 1 edge.
- Word mode: DIVUW a=0xDEAD_BEEF_FFFF_FFFF, b=1 → 0xFFFF_FFFF_FFFF_FFFF after 33 edges. REMW a=-9, b=4 → 0xFFFF_FFFF_FFFF_FFFF.
- Control:
  - Hold out_ready=0 for 10 cycles in DONE → result and out_valid stable, in_ready=0.
  - Assert flush at CALC cycle 20 → IDLE next edge, out_valid never rises.
  - Assert reset mid-CALC → all outputs at reset values immediately.
  - A subsequent DIVU 100/7 still returns 14 at 65 edges.
